// File: rtl/rx_dac_pkg.sv
// Shared definitions for the RX DAC soft-mute stage: per-channel mute state encoding
// and the helper that derives a channel state from its next gain and enable.
package rx_dac_pkg;

  typedef enum logic [1:0] {
    MUTED     = 2'd0,
    RAMP_UP   = 2'd1,
    ACTIVE    = 2'd2,
    RAMP_DOWN = 2'd3
  } ramp_state_t;

  // State is a pure function of where the gain lands and which way it is heading.
  function automatic ramp_state_t ramp_state_of(input logic at_zero,
                                                input logic at_full,
                                                input logic en);
    ramp_state_t s;
    if (en) s = at_full ? ACTIVE : RAMP_UP;
    else    s = at_zero ? MUTED  : RAMP_DOWN;
    return s;
  endfunction

endpackage

// File: rtl/rx_dac_gain_ramp.sv
// Per-channel gain register and mute FSM. With RX_DAC_SOFT_MUTE_EN defined the gain ramps
// linearly by ramp_step per valid beat; otherwise it jumps straight between 0 and full scale.
module rx_dac_gain_ramp
  import rx_dac_pkg::*;
#(
  parameter int unsigned RAMP_WIDTH = 8
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  enable,
  input  logic                  din_valid,
  input  logic [RAMP_WIDTH-1:0] ramp_step,
  output logic [RAMP_WIDTH:0]   g,
  output ramp_state_t           state
);

  localparam logic [RAMP_WIDTH:0] FULL = {1'b1, {RAMP_WIDTH{1'b0}}};

  logic [RAMP_WIDTH:0] g_next;
  ramp_state_t         state_next;

`ifdef RX_DAC_SOFT_MUTE_EN
  logic [RAMP_WIDTH:0]   step;
  logic [RAMP_WIDTH+1:0] up_sum;

  assign step   = (ramp_step == '0) ? (RAMP_WIDTH+1)'(1) : {1'b0, ramp_step};
  assign up_sum = {1'b0, g} + {1'b0, step};
`else
  logic unused_step;
  assign unused_step = ^ramp_step;
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      g     <= '0;
      state <= MUTED;
    end else begin
      g     <= g_next;
      state <= state_next;
    end
  end

  always_comb begin
    g_next     = g;
    state_next = state;
    if (din_valid) begin
`ifdef RX_DAC_SOFT_MUTE_EN
      // Direction follows enable on this very beat, so a reversal starts from the current g.
      if (enable) g_next = (up_sum >= {1'b0, FULL}) ? FULL : up_sum[RAMP_WIDTH:0];
      else        g_next = (g <= step) ? '0 : g - step;
`else
      g_next = enable ? FULL : '0;
`endif
      state_next = ramp_state_of(g_next == '0, g_next == FULL, enable);
    end
  end

endmodule

// File: rtl/rx_dac_soft_mute.sv
// RX DAC output stage: per-channel gain ramp and two-stage rounded/saturated lane multipliers.
// Ramp vs hard mute is selected by the RX_DAC_SOFT_MUTE_EN macro (see rx_dac_gain_ramp).
module rx_dac_soft_mute
  import rx_dac_pkg::*;
#(
  parameter int unsigned NUMBER_OF_LINE = 8,
  parameter int unsigned NUMBER_OF_DAC  = 3,
  parameter int unsigned DATA_WIDTH     = 16,
  parameter int unsigned RAMP_WIDTH     = 8
) (
  input  logic                                             clock,
  input  logic                                             reset_n,
  input  logic [NUMBER_OF_DAC*NUMBER_OF_LINE*DATA_WIDTH-1:0] din,
  input  logic                                             din_valid,
  input  logic [NUMBER_OF_DAC-1:0]                         enable,
  input  logic [RAMP_WIDTH-1:0]                            ramp_step,
  output logic [NUMBER_OF_DAC*NUMBER_OF_LINE*DATA_WIDTH-1:0] dout,
  output logic                                             dout_valid,
  output logic [2*NUMBER_OF_DAC-1:0]                       state,
  output logic [NUMBER_OF_DAC-1:0]                         muted
);

  localparam int unsigned PW = DATA_WIDTH + RAMP_WIDTH + 2;
  localparam logic signed [PW:0] HALF    = (PW+1)'(2 ** (RAMP_WIDTH-1));
  localparam logic signed [PW:0] SAT_MAX = {{(PW-DATA_WIDTH+2){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [PW:0] SAT_MIN = {{(PW-DATA_WIDTH+2){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

  logic valid_s1;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      valid_s1   <= 1'b0;
      dout_valid <= 1'b0;
    end else begin
      valid_s1   <= din_valid;
      dout_valid <= valid_s1;
    end
  end

  for (genvar c = 0; c < NUMBER_OF_DAC; c++) begin : g_ch
    logic [RAMP_WIDTH:0] gain;
    ramp_state_t         ch_state;

    rx_dac_gain_ramp #(.RAMP_WIDTH(RAMP_WIDTH)) u_ramp (
      .clock     (clock),
      .reset_n   (reset_n),
      .enable    (enable[c]),
      .din_valid (din_valid),
      .ramp_step (ramp_step),
      .g         (gain),
      .state     (ch_state)
    );

    assign state[2*c +: 2] = ch_state;
    assign muted[c]        = (ch_state == MUTED);

    for (genvar i = 0; i < NUMBER_OF_LINE; i++) begin : g_lane
      localparam int unsigned IDX = c*NUMBER_OF_LINE + i;

      logic signed [PW-1:0]         x_ext, g_ext, prod_q;
      logic signed [PW:0]           rounded;
      logic signed [DATA_WIDTH-1:0] y_sat, y_q;

      // Gain sampled here is the pre-update value, so the beat that raises enable still sees 0.
      assign x_ext   = PW'($signed(din[DATA_WIDTH*IDX +: DATA_WIDTH]));
      assign g_ext   = $signed(PW'(gain));
      assign rounded = ((PW+1)'(prod_q) + HALF) >>> RAMP_WIDTH;

      always_comb begin
        y_sat = rounded[DATA_WIDTH-1:0];
        if (rounded > SAT_MAX)      y_sat = SAT_MAX[DATA_WIDTH-1:0];
        else if (rounded < SAT_MIN) y_sat = SAT_MIN[DATA_WIDTH-1:0];
      end

      always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
          prod_q <= '0;
          y_q    <= '0;
        end else begin
          prod_q <= x_ext * g_ext;
          y_q    <= y_sat;
        end
      end

      assign dout[DATA_WIDTH*IDX +: DATA_WIDTH] = y_q;
    end
  end

endmodule

// File: tb/tb_rx_dac_soft_mute.sv
// Directed bench for rx_dac_soft_mute; expectations follow RX_DAC_SOFT_MUTE_EN (ramp vs hard mute).
module tb_rx_dac_soft_mute;

  localparam int NL = 8;
  localparam int ND = 3;
  localparam int DW = 16;
  localparam int W  = ND*NL*DW;

  logic          clock = 1'b0;
  logic          reset_n;
  logic [W-1:0]  din;
  logic          din_valid;
  logic [ND-1:0] enable;
  logic [7:0]    ramp_step;
  logic [W-1:0]  dout;
  logic          dout_valid;
  logic [5:0]    state;
  logic [ND-1:0] muted;

  int compared   = 0;
  int mismatched = 0;

  always #5 clock = ~clock;

  rx_dac_soft_mute #(
    .NUMBER_OF_LINE (NL),
    .NUMBER_OF_DAC  (ND),
    .DATA_WIDTH     (DW),
    .RAMP_WIDTH     (8)
  ) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .din        (din),
    .din_valid  (din_valid),
    .enable     (enable),
    .ramp_step  (ramp_step),
    .dout       (dout),
    .dout_valid (dout_valid),
    .state      (state),
    .muted      (muted)
  );

  task automatic set_ch(input int c, input logic [15:0] v);
    for (int i = 0; i < NL; i++) din[DW*(c*NL+i) +: DW] = v;
  endtask

  task automatic apply_reset();
    reset_n = 1'b0; din_valid = 1'b0; enable = '0; din = '0; ramp_step = '0;
    @(posedge clock); #1;
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; enable = '0; din_valid = 1'b0; ramp_step = 8'd64;
    for (int i = 0; i < ND*NL; i++) din[DW*i +: DW] = 16'($urandom);
    repeat (3) @(posedge clock);
    #1;
    compared++; if (dout !== '0) begin mismatched++; $display("FAIL reset_dout: got %0h expected 0", dout); end
    compared++; if (dout_valid !== 1'b0) begin mismatched++; $display("FAIL reset_dout_valid: got %0b expected 0", dout_valid); end
    compared++; if (state !== 6'd0) begin mismatched++; $display("FAIL reset_state: got %0h expected 0", state); end
    compared++; if (muted !== 3'b111) begin mismatched++; $display("FAIL reset_muted: got %0b expected 111", muted); end
    reset_n = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    compared++; if (dout !== '0) begin mismatched++; $display("FAIL post_reset_dout: got %0h expected 0", dout); end
    compared++; if (dout_valid !== 1'b0) begin mismatched++; $display("FAIL post_reset_dout_valid: got %0b expected 0", dout_valid); end
    compared++; if (state !== 6'd0) begin mismatched++; $display("FAIL post_reset_state: got %0h expected 0", state); end
    compared++; if (muted !== 3'b111) begin mismatched++; $display("FAIL post_reset_muted: got %0b expected 111", muted); end
  endtask

  task automatic test_ramp_up();
    int ey [6];
    int es [6];
    logic [127:0] y;
`ifdef RX_DAC_SOFT_MUTE_EN
    ey = '{0, 4096, 8192, 12288, 16384, 16384};
    es = '{1, 1, 1, 2, 2, 2};
`else
    ey = '{0, 16384, 16384, 16384, 16384, 16384};
    es = '{2, 2, 2, 2, 2, 2};
`endif
    apply_reset();
    ramp_step = 8'd64; set_ch(0, 16'd16384); set_ch(1, 16'd1000); set_ch(2, 16'd1000);
    din_valid = 1'b1; enable = 3'b001;
    for (int k = 0; k < 7; k++) begin
      @(posedge clock); #1;
      if (k < 6) begin
        compared++;
        if (state[1:0] !== 2'(es[k])) begin mismatched++; $display("FAIL ramp_state k=%0d: got %0d expected %0d", k, state[1:0], es[k]); end
      end
      compared++;
      if (state[5:2] !== 4'd0) begin mismatched++; $display("FAIL ramp_other_state k=%0d: got %0h expected 0", k, state[5:2]); end
      if (k > 0) begin
        y = {8{16'(ey[k-1])}};
        compared++;
        if (dout[127:0] !== y) begin mismatched++; $display("FAIL ramp_ch0 k=%0d: got %0h expected %0h", k, dout[127:0], y); end
        compared++;
        if (dout[383:128] !== '0) begin mismatched++; $display("FAIL ramp_other_ch k=%0d: got %0h expected 0", k, dout[383:128]); end
        compared++;
        if (dout_valid !== 1'b1) begin mismatched++; $display("FAIL ramp_valid k=%0d: got %0b expected 1", k, dout_valid); end
      end
    end
    compared++; if (muted !== 3'b110) begin mismatched++; $display("FAIL ramp_muted: got %0b expected 110", muted); end
  endtask

  task automatic test_reversal();
    logic en [5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    int ey [5];
    int es [5];
    logic [127:0] y;
`ifdef RX_DAC_SOFT_MUTE_EN
    ey = '{0, 4096, 8192, 4096, 0};
    es = '{1, 1, 3, 0, 0};
`else
    ey = '{0, 16384, 16384, 0, 0};
    es = '{2, 2, 0, 0, 0};
`endif
    apply_reset();
    ramp_step = 8'd64; set_ch(0, 16'd16384); din_valid = 1'b1;
    for (int k = 0; k < 6; k++) begin
      if (k < 5) enable[0] = en[k];
      @(posedge clock); #1;
      if (k < 5) begin
        compared++;
        if (state[1:0] !== 2'(es[k])) begin mismatched++; $display("FAIL rev_state k=%0d: got %0d expected %0d", k, state[1:0], es[k]); end
      end
      if (k > 0) begin
        y = {8{16'(ey[k-1])}};
        compared++;
        if (dout[127:0] !== y) begin mismatched++; $display("FAIL rev_ch0 k=%0d: got %0h expected %0h", k, dout[127:0], y); end
      end
    end
    compared++; if (muted !== 3'b111) begin mismatched++; $display("FAIL rev_muted: got %0b expected 111", muted); end
  endtask

  task automatic test_valid_gap();
    logic vld [7] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    int ey [7];
    int es [7];
    logic [127:0] y;
`ifdef RX_DAC_SOFT_MUTE_EN
    ey = '{0, 4096, 0, 0, 0, 8192, 12288};
    es = '{1, 1, 1, 1, 1, 1, 2};
`else
    ey = '{0, 16384, 0, 0, 0, 16384, 16384};
    es = '{2, 2, 2, 2, 2, 2, 2};
`endif
    apply_reset();
    ramp_step = 8'd64; set_ch(0, 16'd16384); enable = 3'b001;
    for (int k = 0; k < 8; k++) begin
      din_valid = (k < 7) ? vld[k] : 1'b0;
      @(posedge clock); #1;
      if (k < 7) begin
        compared++;
        if (state[1:0] !== 2'(es[k])) begin mismatched++; $display("FAIL gap_state k=%0d: got %0d expected %0d", k, state[1:0], es[k]); end
      end
      if (k > 0) begin
        compared++;
        if (dout_valid !== vld[k-1]) begin mismatched++; $display("FAIL gap_valid k=%0d: got %0b expected %0b", k, dout_valid, vld[k-1]); end
        if (vld[k-1]) begin
          y = {8{16'(ey[k-1])}};
          compared++;
          if (dout[127:0] !== y) begin mismatched++; $display("FAIL gap_ch0 k=%0d: got %0h expected %0h", k, dout[127:0], y); end
        end
      end
    end
  endtask

  task automatic test_arith_corners();
    logic [15:0] e_m1, e_half;
`ifdef RX_DAC_SOFT_MUTE_EN
    e_m1 = 16'h0000; e_half = 16'd8192;
`else
    e_m1 = 16'hFFFF; e_half = 16'd16384;
`endif
    apply_reset();
    ramp_step = 8'd128; enable = 3'b001; din_valid = 1'b1;
    @(posedge clock); #1;
    din[15:0] = 16'd1; din[31:16] = 16'hFFFF; din[47:32] = 16'd16384;
    @(posedge clock); #1;
    compared++; if (state[1:0] !== 2'd2) begin mismatched++; $display("FAIL arith_state: got %0d expected 2", state[1:0]); end
    din[15:0] = 16'h8000; din[31:16] = 16'h7FFF; din[47:32] = 16'd0;
    @(posedge clock); #1;
    compared++; if (dout[15:0] !== 16'd1) begin mismatched++; $display("FAIL arith_plus1: got %0h expected 1", dout[15:0]); end
    compared++; if (dout[31:16] !== e_m1) begin mismatched++; $display("FAIL arith_minus1: got %0h expected %0h", dout[31:16], e_m1); end
    compared++; if (dout[47:32] !== e_half) begin mismatched++; $display("FAIL arith_half: got %0h expected %0h", dout[47:32], e_half); end
    @(posedge clock); #1;
    compared++; if (dout[15:0] !== 16'h8000) begin mismatched++; $display("FAIL arith_min: got %0h expected 8000", dout[15:0]); end
    compared++; if (dout[31:16] !== 16'h7FFF) begin mismatched++; $display("FAIL arith_max: got %0h expected 7fff", dout[31:16]); end
  endtask

  task automatic test_step_zero_async_reset();
    logic [1:0]  s255;
    logic [15:0] y100;
`ifdef RX_DAC_SOFT_MUTE_EN
    s255 = 2'd1; y100 = 16'd6272;
`else
    s255 = 2'd2; y100 = 16'd16384;
`endif
    apply_reset();
    ramp_step = 8'd0; enable = 3'b001; set_ch(0, 16'd16384); din_valid = 1'b1;
    repeat (255) @(posedge clock);
    #1;
    compared++; if (state[1:0] !== s255) begin mismatched++; $display("FAIL step0_beat255: got %0d expected %0d", state[1:0], s255); end
    @(posedge clock); #1;
    compared++; if (state[1:0] !== 2'd2) begin mismatched++; $display("FAIL step0_beat256: got %0d expected 2", state[1:0]); end

    apply_reset();
    ramp_step = 8'd0; enable = 3'b001; set_ch(0, 16'd16384); din_valid = 1'b1;
    repeat (100) @(posedge clock);
    #1;
    compared++; if (dout[15:0] !== y100) begin mismatched++; $display("FAIL step0_beat100_dout: got %0d expected %0d", dout[15:0], y100); end
    #2 reset_n = 1'b0;
    #1;
    compared++; if (dout !== '0) begin mismatched++; $display("FAIL async_dout: got %0h expected 0", dout); end
    compared++; if (dout_valid !== 1'b0) begin mismatched++; $display("FAIL async_valid: got %0b expected 0", dout_valid); end
    compared++; if (state !== 6'd0) begin mismatched++; $display("FAIL async_state: got %0h expected 0", state); end
    compared++; if (muted !== 3'b111) begin mismatched++; $display("FAIL async_muted: got %0b expected 111", muted); end
    @(posedge clock); #1;
    reset_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_ramp_up();
    test_reversal();
    test_valid_gap();
    test_arith_corners();
    test_step_zero_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
